// File: rtl/alu_hilo_sched_pkg.sv
// Shared op encodings, FSM state type and op-class helpers for the ALU issue controller.
package alu_hilo_sched_pkg;

    localparam int unsigned OpW   = 5;
    localparam int unsigned DataW = 32;

    localparam logic [OpW-1:0] ALUOP_NOP   = 5'd0;
    localparam logic [OpW-1:0] ALUOP_ADD   = 5'd1;
    localparam logic [OpW-1:0] ALUOP_ADDU  = 5'd2;
    localparam logic [OpW-1:0] ALUOP_SUB   = 5'd3;
    localparam logic [OpW-1:0] ALUOP_SUBU  = 5'd4;
    localparam logic [OpW-1:0] ALUOP_AND   = 5'd5;
    localparam logic [OpW-1:0] ALUOP_OR    = 5'd6;
    localparam logic [OpW-1:0] ALUOP_XOR   = 5'd7;
    localparam logic [OpW-1:0] ALUOP_NOR   = 5'd8;
    localparam logic [OpW-1:0] ALUOP_SLT   = 5'd9;
    localparam logic [OpW-1:0] ALUOP_SLTU  = 5'd10;
    localparam logic [OpW-1:0] ALUOP_SLL   = 5'd11;
    localparam logic [OpW-1:0] ALUOP_SRL   = 5'd12;
    localparam logic [OpW-1:0] ALUOP_SRA   = 5'd13;
    localparam logic [OpW-1:0] ALUOP_MULT  = 5'd14;
    localparam logic [OpW-1:0] ALUOP_MULTU = 5'd15;
    localparam logic [OpW-1:0] ALUOP_DIV   = 5'd16;
    localparam logic [OpW-1:0] ALUOP_DIVU  = 5'd17;
    localparam logic [OpW-1:0] ALUOP_LUI   = 5'd18;
    // HI/LO moves live in a range the ALU never decodes.
    localparam logic [OpW-1:0] ALUOP_MFHI  = 5'd24;
    localparam logic [OpW-1:0] ALUOP_MFLO  = 5'd25;
    localparam logic [OpW-1:0] ALUOP_MTHI  = 5'd26;
    localparam logic [OpW-1:0] ALUOP_MTLO  = 5'd27;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMdWait,
        StResp
    } state_e;

    function automatic logic is_mul(input logic [OpW-1:0] op);
        return (op == ALUOP_MULT) || (op == ALUOP_MULTU);
    endfunction

    function automatic logic is_div(input logic [OpW-1:0] op);
        return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
    endfunction

    function automatic logic is_hilo_move(input logic [OpW-1:0] op);
        return (op == ALUOP_MFHI) || (op == ALUOP_MFLO) ||
               (op == ALUOP_MTHI) || (op == ALUOP_MTLO);
    endfunction

endpackage

// File: rtl/alu_hilo_sched_if.sv
// Request/response handshake bundle between issue logic and the ALU issue controller.
interface alu_hilo_sched_if;
    import alu_hilo_sched_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [OpW-1:0]   op;
    logic [DataW-1:0] src0;
    logic [DataW-1:0] src1;

    logic             res_valid;
    logic             res_ready;
    logic [DataW-1:0] res_data;
    logic             res_zero;

    modport master (
        output req_valid, op, src0, src1, res_ready,
        input  req_ready, res_valid, res_data, res_zero
    );

    modport slave (
        input  req_valid, op, src0, src1, res_ready,
        output req_ready, res_valid, res_data, res_zero
    );

endinterface

// File: rtl/alu_hilo_sched_hilo_regfile.sv
// Architectural HI/LO register pair with independent write enables.
module alu_hilo_sched_hilo_regfile
    import alu_hilo_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [DataW-1:0] hi_wdata_i,
    input  logic [DataW-1:0] lo_wdata_i,
    output logic [DataW-1:0] hi_o,
    output logic [DataW-1:0] lo_o
);

    logic [DataW-1:0] hi_q, hi_d;
    logic [DataW-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_we_i ? hi_wdata_i : hi_q;
        lo_d = lo_we_i ? lo_wdata_i : lo_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/alu_hilo_sched.sv
// Issue controller in front of the combinational ALU: registers operands, owns HI/LO and
// stalls the requester for the modelled MULT/DIV latency.
module alu_hilo_sched
    import alu_hilo_sched_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    alu_hilo_sched_if.slave  bus_io,
    output logic [OpW-1:0]   alu_ctrl_o,
    output logic [DataW-1:0] alu_src0_o,
    output logic [DataW-1:0] alu_src1_o,
    input  logic [63:0]      alu_result_i,
    input  logic             alu_zero_i,
    output logic [DataW-1:0] hi_o,
    output logic [DataW-1:0] lo_o,
    output logic             div0_o
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    state_e           state_q;
    logic [OpW-1:0]   op_q;
    logic [OpW-1:0]   alu_ctrl_q;
    logic [DataW-1:0] alu_src0_q;
    logic [DataW-1:0] alu_src1_q;
    logic [CntW-1:0]  cnt_q;
    logic             req_ready_q;
    logic             res_valid_q;
    logic [DataW-1:0] res_data_q;
    logic             res_zero_q;
    logic             div0_q;

    logic             md_done;
    logic             div0_hit;
    logic             hi_we, lo_we;
    logic [DataW-1:0] hi_wdata, lo_wdata;
    logic [DataW-1:0] exec_data;
    logic [DataW-1:0] md_data;

    assign md_done  = (state_q == StMdWait) && (cnt_q == CntW'(1));
    assign div0_hit = is_div(op_q) && (alu_src1_q == '0);
    // A zero divisor leaves HI/LO alone, so the reported word is the old LO.
    assign md_data  = div0_hit ? lo_o : alu_result_i[DataW-1:0];

    always_comb begin
        exec_data = alu_result_i[DataW-1:0];
        case (op_q)
            ALUOP_MFHI:             exec_data = hi_o;
            ALUOP_MFLO:             exec_data = lo_o;
            ALUOP_MTHI, ALUOP_MTLO: exec_data = alu_src0_q;
            default:                exec_data = alu_result_i[DataW-1:0];
        endcase
    end

    always_comb begin
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdata = alu_result_i[63:32];
        lo_wdata = alu_result_i[DataW-1:0];
        if (state_q == StExec) begin
            if (op_q == ALUOP_MTHI) begin
                hi_we    = 1'b1;
                hi_wdata = alu_src0_q;
            end
            if (op_q == ALUOP_MTLO) begin
                lo_we    = 1'b1;
                lo_wdata = alu_src0_q;
            end
        end else if (md_done && !div0_hit) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
        end
    end

    alu_hilo_sched_hilo_regfile u_hilo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .hi_we_i    (hi_we),
        .lo_we_i    (lo_we),
        .hi_wdata_i (hi_wdata),
        .lo_wdata_i (lo_wdata),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            op_q        <= ALUOP_NOP;
            alu_ctrl_q  <= ALUOP_NOP;
            alu_src0_q  <= '0;
            alu_src1_q  <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            div0_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus_io.req_valid) begin
                        op_q        <= bus_io.op;
                        alu_ctrl_q  <= is_hilo_move(bus_io.op) ? ALUOP_NOP : bus_io.op;
                        alu_src0_q  <= bus_io.src0;
                        alu_src1_q  <= bus_io.src1;
                        req_ready_q <= 1'b0;
                        if (is_mul(bus_io.op) || is_div(bus_io.op)) begin
                            cnt_q   <= is_div(bus_io.op) ? CntW'(DIV_LAT) : CntW'(MUL_LAT);
                            state_q <= StMdWait;
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    res_data_q  <= exec_data;
                    res_zero_q  <= alu_zero_i;
                    res_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StMdWait: begin
                    if (md_done) begin
                        res_data_q  <= md_data;
                        res_zero_q  <= alu_zero_i;
                        res_valid_q <= 1'b1;
                        div0_q      <= div0_hit;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    if (bus_io.res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.req_ready = req_ready_q;
    assign bus_io.res_valid = res_valid_q;
    assign bus_io.res_data  = res_data_q;
    assign bus_io.res_zero  = res_zero_q;
    assign alu_ctrl_o       = alu_ctrl_q;
    assign alu_src0_o       = alu_src0_q;
    assign alu_src1_o       = alu_src1_q;
    assign div0_o           = div0_q;

endmodule

// File: tb/tb_alu_hilo_sched.sv
// Scoreboard bench: directed and random ops against a reference model, with a stub ALU.
module tb_alu_hilo_sched;
    import alu_hilo_sched_pkg::*;

    localparam int unsigned MulLat = 4;
    localparam int unsigned DivLat = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_hilo_sched_if bus_if ();

    logic [4:0]  alu_ctrl;
    logic [31:0] alu_src0, alu_src1;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic [31:0] hi, lo;
    logic        div0;

    alu_hilo_sched #(
        .MUL_LAT (MulLat),
        .DIV_LAT (DivLat)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus_io       (bus_if),
        .alu_ctrl_o   (alu_ctrl),
        .alu_src0_o   (alu_src0),
        .alu_src1_o   (alu_src1),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .hi_o         (hi),
        .lo_o         (lo),
        .div0_o       (div0)
    );

    // Behavioural ALU: {hi,lo}; DIV gives {rem,quot}.
    function automatic logic [63:0] alu_fn(input logic [4:0] c, input logic [31:0] a, b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (c)
            ALUOP_NOP:              return 64'h0;
            ALUOP_ADD, ALUOP_ADDU:  return {32'h0, a + b};
            ALUOP_SUB, ALUOP_SUBU:  return {32'h0, a - b};
            ALUOP_AND:              return {32'h0, a & b};
            ALUOP_OR:               return {32'h0, a | b};
            ALUOP_XOR:              return {32'h0, a ^ b};
            ALUOP_NOR:              return {32'h0, ~(a | b)};
            ALUOP_SLT:              return {63'h0, $signed(a) < $signed(b)};
            ALUOP_SLTU:             return {63'h0, a < b};
            ALUOP_SLL:              return {32'h0, b << a[4:0]};
            ALUOP_SRL:              return {32'h0, b >> a[4:0]};
            ALUOP_SRA:              return {32'h0, 32'($signed(b) >>> a[4:0])};
            ALUOP_LUI:              return {32'h0, b << 16};
            ALUOP_MULT:             return sa * sb;
            ALUOP_MULTU:            return {32'h0, a} * {32'h0, b};
            ALUOP_DIV:  if (b == 0) return 64'h0;
                        else        return {32'(sa % sb), 32'(sa / sb)};
            ALUOP_DIVU: if (b == 0) return 64'h0;
                        else        return {a % b, a / b};
            default:                return {32'h0, 32'hBAD0_0000 | {27'h0, c}};
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_ctrl, alu_src0, alu_src1);
        alu_zero   = (alu_result[31:0] == 32'h0);
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [31:0] data;
        logic        chk_zero;
        logic        zero;
        logic [31:0] hi, lo;
        logic        div0;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
    int          cyc = 0;
    int          checks = 0, errors = 0;
    bit          in_resp = 1'b0;
    int          hold_cnt = 0;
    bit          rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural effect of one op on HI/LO and the reported word.
    task automatic model(input logic [4:0] op, input logic [31:0] a, b, output exp_t e);
        logic [63:0] r;
        e.op = op; e.a = a; e.b = b;
        e.div0 = 1'b0; e.chk_zero = 1'b0; e.zero = 1'b0; e.lat = 2; e.acc_cyc = 0;
        case (op)
            ALUOP_MFHI: e.data = m_hi;
            ALUOP_MFLO: e.data = m_lo;
            ALUOP_MTHI: begin m_hi = a; e.data = a; end
            ALUOP_MTLO: begin m_lo = a; e.data = a; end
            ALUOP_MULT, ALUOP_MULTU: begin
                r = alu_fn(op, a, b);
                m_hi = r[63:32]; m_lo = r[31:0];
                e.data = m_lo; e.lat = MulLat + 1;
            end
            ALUOP_DIV, ALUOP_DIVU: begin
                e.lat = DivLat + 1;
                if (b == 0) e.div0 = 1'b1;
                else begin
                    r = alu_fn(op, a, b);
                    m_hi = r[63:32]; m_lo = r[31:0];
                end
                e.data = m_lo;
            end
            default: begin
                r = alu_fn(op, a, b);
                e.data = r[31:0]; e.chk_zero = 1'b1; e.zero = (r[31:0] == 32'h0);
            end
        endcase
        e.hi = m_hi; e.lo = m_lo;
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, b);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.op = op; bus_if.src0 = a; bus_if.src1 = b;
        while (!bus_if.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus_if.req_ready) begin
            chk("req_ready_timeout", 64'(bus_if.req_ready), 64'h1);
        end else begin
            model(op, a, b, e);
            e.acc_cyc = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        bus_if.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || in_resp) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_outstanding", 64'(q.size()) + 64'(in_resp), 64'h0);
    endtask

    // Consumer-side ready: changes just after posedge, so it is stable at negedge.
    initial begin
        bus_if.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                bus_if.res_ready = 1'b0;
                hold_cnt--;
            end else begin
                bus_if.res_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: pops on the first cycle of each response, then checks it holds until taken.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_resp = 1'b0;
            end else if (bus_if.res_valid && !in_resp) begin
                in_resp = 1'b1;
                if (q.size() == 0) begin
                    chk("unexpected_response", 64'(bus_if.res_valid), 64'h0);
                end else begin
                    cur = q.pop_front();
                    chk("latency", 64'(cyc - cur.acc_cyc), 64'(cur.lat));
                    chk("res_data", 64'(bus_if.res_data), 64'(cur.data));
                    chk("hi", 64'(hi), 64'(cur.hi));
                    chk("lo", 64'(lo), 64'(cur.lo));
                    chk("div0_pulse", 64'(div0), 64'(cur.div0));
                    chk("alu_src0_held", 64'(alu_src0), 64'(cur.a));
                    chk("alu_src1_held", 64'(alu_src1), 64'(cur.b));
                    chk("req_ready_in_resp", 64'(bus_if.req_ready), 64'h0);
                    if (cur.chk_zero) chk("res_zero", 64'(bus_if.res_zero), 64'(cur.zero));
                end
            end else if (bus_if.res_valid) begin
                chk("res_data_stable", 64'(bus_if.res_data), 64'(cur.data));
                chk("div0_single_cycle", 64'(div0), 64'h0);
                chk("req_ready_stall", 64'(bus_if.req_ready), 64'h0);
            end else begin
                chk("div0_idle", 64'(div0), 64'h0);
            end
            if (!rst && bus_if.res_valid && bus_if.res_ready) in_resp = 1'b0;
        end
    end

    logic [4:0] op_tab [0:21] = '{
        ALUOP_NOP, ALUOP_ADD, ALUOP_ADDU, ALUOP_SUB, ALUOP_SUBU, ALUOP_AND, ALUOP_OR,
        ALUOP_XOR, ALUOP_NOR, ALUOP_SLT, ALUOP_SLTU, ALUOP_SLL, ALUOP_SRL, ALUOP_SRA,
        ALUOP_MULT, ALUOP_MULTU, ALUOP_DIV, ALUOP_DIVU, ALUOP_MFHI, ALUOP_MTLO,
        ALUOP_MFLO, 5'd20
    };

    function automatic logic [31:0] rand_word();
        case ($urandom_range(3))
            0:       return 32'h0;
            1:       return 32'($urandom_range(20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.op = 5'h0; bus_if.src0 = 32'h0; bus_if.src1 = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 64'(bus_if.req_ready), 64'h1);
        chk("rst_res_valid", 64'(bus_if.res_valid), 64'h0);
        chk("rst_res_data", 64'(bus_if.res_data), 64'h0);
        chk("rst_res_zero", 64'(bus_if.res_zero), 64'h0);
        chk("rst_div0", 64'(div0), 64'h0);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(ALUOP_NOP));
        chk("rst_alu_src0", 64'(alu_src0), 64'h0);
        chk("rst_alu_src1", 64'(alu_src1), 64'h0);

        send(ALUOP_ADD, 32'd3, 32'd4);
        send(ALUOP_SUB, 32'd5, 32'd5);
        send(ALUOP_SUB, 32'd5, 32'd4);
        send(ALUOP_MULT, 32'hFFFF_FFFF, 32'd2);
        send(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2);
        send(ALUOP_MFHI, 32'h0, 32'h0);
        send(ALUOP_DIVU, 32'd10, 32'd0);
        send(ALUOP_MTLO, 32'h1234, 32'h0);
        send(ALUOP_MFLO, 32'h0, 32'h0);
        hold_cnt = 9;
        send(ALUOP_XOR, 32'hF0F0_0000, 32'h0F0F_1111);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            send(op_tab[$urandom_range(21)], rand_word(), rand_word());
        end
        drain();
        rand_rdy = 1'b0;

        // Reset while a MULT is counting down: result dropped, HI/LO cleared.
        send(ALUOP_MTHI, 32'hA5A5_0001, 32'h0);
        send(ALUOP_MTLO, 32'h5A5A_0002, 32'h0);
        drain();
        send(ALUOP_MULT, 32'd7, 32'd9);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        chk("midop_rst_req_ready", 64'(bus_if.req_ready), 64'h1);
        chk("midop_rst_res_valid", 64'(bus_if.res_valid), 64'h0);
        chk("midop_rst_hi", 64'(hi), 64'h0);
        chk("midop_rst_lo", 64'(lo), 64'h0);
        repeat (12) @(negedge clk);
        chk("after_rst_hi", 64'(hi), 64'h0);
        chk("after_rst_lo", 64'(lo), 64'h0);
        send(ALUOP_ADD, 32'd1, 32'd2);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
